video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Runtime-programmable raster timing generator, successor to the fixed PAL/NTSC sync generator. It produces sync, blanking, active and pixel coordinates, plus the periodic line-based timer interrupt, for the PCW video path. Timing fields are loaded through a valid/busy handshake and take effect only at a frame boundary, so the raster never tears. Default parameters give 720x256 in a 1024x312 frame, with a 52-line timer.

## Interface
Parameters:
- HW, 11: horizontal counter and field width.
- VW, 10: vertical counter and field width.
- TW, 6: timer period width.
- SYNC_NEG, 1: 1 = o_hs/o_vs active low.
- DEF_H_FP / DEF_H_SYNC / DEF_H_BP / DEF_H_ACT, 96/64/144/720: reset horizontal fields.
- DEF_V_ACT / DEF_V_FP / DEF_V_SYNC / DEF_V_BP, 256/26/4/26: reset vertical fields.
- DEF_T_PERIOD, 52: reset timer period, in lines.
- DEF_T_SYNC, 288: reset timer resync line.

Ports:
- i_clk  in  1  base clock.
- i_rst  in  1  reset. Asynchronous, active-high.
- i_pix_stb  in  1  pixel strobe; all counting is qualified by it.
- i_cfg_valid  in  1  one-cycle load request.
- i_h_fp, i_h_sync, i_h_bp, i_h_act  in  HW each  horizontal fields.
- i_v_act, i_v_fp, i_v_sync, i_v_bp  in  VW each  vertical fields.
- i_t_period  in  TW  timer period in lines; 0 = timer disabled.
- i_t_sync  in  VW  timer resync line.
- o_cfg_busy  out  1  new config pending.
- o_cfg_err  out  1  one-cycle reject pulse.
- o_hs, o_vs  out  1  syncs.
- o_hblank, o_vblank, o_active  out  1  blanking and active.
- o_x  out  HW  pixel x.
- o_y  out  VW  pixel y.
- o_line_start, o_frame_start, o_animate  out  1  one-strobe markers.
- o_timer  out  1  timer tick.

## Operation
- **Horizontal order.** h_count 0 begins FP, then SYNC, then BP, then ACTIVE.
  - LINE = fp+sync+bp+act.
  - HA_STA = fp+sync+bp.
- **Vertical order.** v_count 0 begins ACTIVE, then FP, then SYNC, then BP.
  - FRAME = act+fp+sync+bp.
  - VS_STA = act+fp.
  - VS_END = VS_STA+sync.
- **Counters.** On i_pix_stb, h_count increments. At LINE-1 it wraps to 0 and v_count increments. At FRAME-1, on the wrap, v_count also wraps to 0. This wrap is the "frame wrap".
- **Decodes** are combinational from the counters and the active config:
  - hs asserted for h in [fp, fp+sync). vs asserted for v in [VS_STA, VS_END). Polarity is set by SYNC_NEG.
  - hblank = h<HA_STA. vblank = v>=act. active = !hblank & !vblank.
  - o_x = hblank ? 0 : h-HA_STA. o_y = vblank ? act-1 : v.
  - o_line_start = h==0.
  - o_frame_start = h==0 & v==0.
  - o_animate = v==act-1 & h==LINE-1.
- **Config FSM**, states IDLE and PEND.
  - On i_cfg_valid, the fields are validated. A config is rejected if any of these holds:
    - any field is 0;
    - LINE>2^HW-1 or FRAME>2^VW-1, with sums computed at HW+2 / VW+2 bits;
    - i_t_sync>=FRAME.
  - Rejected config: pulse o_cfg_err for one cycle. The state and the shadow are unchanged.
  - Accepted config: copy into the shadow and go to PEND.
  - A valid request in PEND overwrites the shadow; last write wins.
  - In PEND, on the frame wrap, the shadow is copied to the active config and the FSM returns to IDLE.
  - o_cfg_busy = (state==PEND).
- **Timer.**
  - t_count reloads to period-1 on reset, and on every tick.
  - At each line end, a tick is issued if t_count==0 or v_count==t_sync. Otherwise t_count decrements.
  - o_timer is registered. It is high for exactly one pixel-strobe period after the tick line end and clears on the next i_pix_stb.
  - A period change applied at the frame wrap reloads t_count to new_period-1.
  - With period 0, o_timer is never asserted.

## Timing
- **Reset** (async; clears immediately, independent of clock):
  - h=0, v=0, state IDLE, active config = DEF_*, t_count = DEF_T_PERIOD-1.
  - o_timer=0, o_cfg_busy=0, o_cfg_err=0.
  - Decoded outputs take their h=0/v=0 values: hs/vs deasserted, hblank=1, vblank=0, active=0, x=0, y=0, line_start=1, frame_start=1, animate=0.
- **Reset release.** Counting resumes on the first i_pix_stb after deassertion. Reset mid-PEND discards the shadow.
- **Config latency.**
  - o_cfg_busy rises the cycle after i_cfg_valid.
  - It falls the cycle after the frame-wrap strobe.
  - The first pixel (h=0, v=0) already uses the new fields.
- **Simultaneous events.**
  - i_cfg_valid in the frame-wrap cycle is captured into the shadow. The old shadow (if any) is applied at this wrap; the new one waits for the next wrap.
  - When t_count==0 and v==t_sync occur together, a single tick is issued.
- **Gaps.** With i_pix_stb low, everything holds except the cfg FSM capture and the o_cfg_err pulse.

## Test plan
- **Defaults.** Reset, then strobe every cycle.
  - hs low for h 96..159; active from h=304.
  - LINE=1024, FRAME=312.
  - vs low for v 282..285.
  - o_animate at v=255, h=1023.
- **Timer.** Defaults.
  - Ticks at line ends of v=51, 103, 155, 207, 259.
  - Forced resync tick at v=288.
  - Next ticks at 340-312=28 lines later, etc.
  - o_timer is high for exactly 1 strobe each time.
- **Mode switch.** Load NTSC at v=100: act 200, fp 30, sync 4, bp 26.
  - busy=1 until the frame wrap at v=311.
  - Next frame FRAME=260, vs at v 230..233.
- **Rejects.** i_h_sync=0 -> o_cfg_err 1 cycle, busy stays 0. i_v_bp=1023 -> reject.
- **Overwrite/collision.** Two valid loads in one frame -> the second applies. Load issued exactly in the wrap cycle -> applies one frame later.
- **Async reset.** Assert mid-line with no clock edge -> outputs reach their reset values immediately. Any pending config is lost.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator with a line-based timer.
// Timing fields are double-buffered and swap in only at the frame wrap.
module video_timing_gen #(
   parameter int HW           = 11,
   parameter int VW           = 10,
   parameter int TW           = 6,
   parameter bit SYNC_NEG     = 1'b1,
   parameter int DEF_H_FP     = 96,
   parameter int DEF_H_SYNC   = 64,
   parameter int DEF_H_BP     = 144,
   parameter int DEF_H_ACT    = 720,
   parameter int DEF_V_ACT    = 256,
   parameter int DEF_V_FP     = 26,
   parameter int DEF_V_SYNC   = 4,
   parameter int DEF_V_BP     = 26,
   parameter int DEF_T_PERIOD = 52,
   parameter int DEF_T_SYNC   = 288
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_pix_stb,
   input  logic          i_cfg_valid,
   input  logic [HW-1:0] i_h_fp,
   input  logic [HW-1:0] i_h_sync,
   input  logic [HW-1:0] i_h_bp,
   input  logic [HW-1:0] i_h_act,
   input  logic [VW-1:0] i_v_act,
   input  logic [VW-1:0] i_v_fp,
   input  logic [VW-1:0] i_v_sync,
   input  logic [VW-1:0] i_v_bp,
   input  logic [TW-1:0] i_t_period,
   input  logic [VW-1:0] i_t_sync,
   output logic          o_cfg_busy,
   output logic          o_cfg_err,
   output logic          o_hs,
   output logic          o_vs,
   output logic          o_hblank,
   output logic          o_vblank,
   output logic          o_active,
   output logic [HW-1:0] o_x,
   output logic [VW-1:0] o_y,
   output logic          o_line_start,
   output logic          o_frame_start,
   output logic          o_animate,
   output logic          o_timer
);

   localparam logic [HW-1:0] RST_H_FP     = HW'(DEF_H_FP);
   localparam logic [HW-1:0] RST_H_SYNC   = HW'(DEF_H_SYNC);
   localparam logic [HW-1:0] RST_H_BP     = HW'(DEF_H_BP);
   localparam logic [HW-1:0] RST_H_ACT    = HW'(DEF_H_ACT);
   localparam logic [VW-1:0] RST_V_ACT    = VW'(DEF_V_ACT);
   localparam logic [VW-1:0] RST_V_FP     = VW'(DEF_V_FP);
   localparam logic [VW-1:0] RST_V_SYNC   = VW'(DEF_V_SYNC);
   localparam logic [VW-1:0] RST_V_BP     = VW'(DEF_V_BP);
   localparam logic [TW-1:0] RST_T_PERIOD = TW'(DEF_T_PERIOD);
   localparam logic [VW-1:0] RST_T_SYNC   = VW'(DEF_T_SYNC);
   localparam logic [TW-1:0] RST_T_CNT    = TW'(DEF_T_PERIOD - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

   state_t        state_r, state_nx_s;
   logic          cap_s, apply_s, cfg_ok_s, err_r, timer_r, tick_s;
   logic [HW+1:0] cfg_line_s;
   logic [VW+1:0] cfg_frame_s;

   // Active timing fields (what the raster uses) and the pending shadow copy.
   logic [HW-1:0] h_fp_r, h_sync_r, h_bp_r, h_act_r;
   logic [VW-1:0] v_act_r, v_fp_r, v_sync_r, v_bp_r, t_sync_r;
   logic [TW-1:0] t_period_r;
   logic [HW-1:0] sh_h_fp_r, sh_h_sync_r, sh_h_bp_r, sh_h_act_r;
   logic [VW-1:0] sh_v_act_r, sh_v_fp_r, sh_v_sync_r, sh_v_bp_r, sh_t_sync_r;
   logic [TW-1:0] sh_t_period_r;

   logic [HW-1:0] h_count_r, line_s, ha_sta_s, hs_end_s;
   logic [VW-1:0] v_count_r, frame_s, vs_sta_s, vs_end_s;
   logic [TW-1:0] t_count_r;
   logic          h_end_s, v_end_s, line_end_s, frame_wrap_s;
   logic          hs_on_s, vs_on_s, hblank_s, vblank_s;

   // Accepted configs guarantee these sums fit in the counter widths.
   assign ha_sta_s     = h_fp_r + h_sync_r + h_bp_r;
   assign line_s       = ha_sta_s + h_act_r;
   assign hs_end_s     = h_fp_r + h_sync_r;
   assign vs_sta_s     = v_act_r + v_fp_r;
   assign vs_end_s     = vs_sta_s + v_sync_r;
   assign frame_s      = vs_end_s + v_bp_r;
   assign h_end_s      = (h_count_r == line_s - HW'(1'b1));
   assign v_end_s      = (v_count_r == frame_s - VW'(1'b1));
   assign line_end_s   = i_pix_stb & h_end_s;
   assign frame_wrap_s = line_end_s & v_end_s;

   // Validate the request; sums are two bits wider so overflow is visible.
   always_comb begin
      cfg_line_s  = {2'b00, i_h_fp} + {2'b00, i_h_sync} + {2'b00, i_h_bp} + {2'b00, i_h_act};
      cfg_frame_s = {2'b00, i_v_act} + {2'b00, i_v_fp} + {2'b00, i_v_sync} + {2'b00, i_v_bp};
      cfg_ok_s    = 1'b1;
      if (~|i_h_fp || ~|i_h_sync || ~|i_h_bp || ~|i_h_act ||
          ~|i_v_act || ~|i_v_fp || ~|i_v_sync || ~|i_v_bp) begin
         cfg_ok_s = 1'b0;
      end else if (cfg_line_s > {2'b00, {HW{1'b1}}}) begin
         cfg_ok_s = 1'b0;
      end else if (cfg_frame_s > {2'b00, {VW{1'b1}}}) begin
         cfg_ok_s = 1'b0;
      end else if ({2'b00, i_t_sync} >= cfg_frame_s) begin
         cfg_ok_s = 1'b0;
      end else begin
         cfg_ok_s = 1'b1;
      end
   end

   // Config FSM next state: a good request always (re)captures; PEND applies at the wrap.
   always_comb begin
      state_nx_s = state_r;
      cap_s      = 1'b0;
      apply_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (i_cfg_valid && cfg_ok_s) begin
               cap_s      = 1'b1;
               state_nx_s = ST_PEND;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_PEND: begin
            apply_s = frame_wrap_s;
            if (i_cfg_valid && cfg_ok_s) begin
               cap_s      = 1'b1;
               state_nx_s = ST_PEND;
            end else if (frame_wrap_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_PEND;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register and the one-cycle reject pulse (not gated by the strobe).
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         err_r   <= i_cfg_valid & ~cfg_ok_s;
      end
   end

   // Shadow and active field registers; reset drops any pending shadow.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         {sh_h_fp_r, sh_h_sync_r, sh_h_bp_r, sh_h_act_r} <= {RST_H_FP, RST_H_SYNC, RST_H_BP, RST_H_ACT};
         {sh_v_act_r, sh_v_fp_r, sh_v_sync_r, sh_v_bp_r} <= {RST_V_ACT, RST_V_FP, RST_V_SYNC, RST_V_BP};
         {sh_t_period_r, sh_t_sync_r}                    <= {RST_T_PERIOD, RST_T_SYNC};
         {h_fp_r, h_sync_r, h_bp_r, h_act_r}             <= {RST_H_FP, RST_H_SYNC, RST_H_BP, RST_H_ACT};
         {v_act_r, v_fp_r, v_sync_r, v_bp_r}             <= {RST_V_ACT, RST_V_FP, RST_V_SYNC, RST_V_BP};
         {t_period_r, t_sync_r}                          <= {RST_T_PERIOD, RST_T_SYNC};
      end else begin
         if (apply_s) begin
            {h_fp_r, h_sync_r, h_bp_r, h_act_r} <= {sh_h_fp_r, sh_h_sync_r, sh_h_bp_r, sh_h_act_r};
            {v_act_r, v_fp_r, v_sync_r, v_bp_r} <= {sh_v_act_r, sh_v_fp_r, sh_v_sync_r, sh_v_bp_r};
            {t_period_r, t_sync_r}              <= {sh_t_period_r, sh_t_sync_r};
         end
         if (cap_s) begin
            {sh_h_fp_r, sh_h_sync_r, sh_h_bp_r, sh_h_act_r} <= {i_h_fp, i_h_sync, i_h_bp, i_h_act};
            {sh_v_act_r, sh_v_fp_r, sh_v_sync_r, sh_v_bp_r} <= {i_v_act, i_v_fp, i_v_sync, i_v_bp};
            {sh_t_period_r, sh_t_sync_r}                    <= {i_t_period, i_t_sync};
         end
      end
   end

   // Raster counters, advanced only on the pixel strobe.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         h_count_r <= {HW{1'b0}};
         v_count_r <= {VW{1'b0}};
      end else if (i_pix_stb) begin
         if (h_end_s) begin
            h_count_r <= {HW{1'b0}};
            v_count_r <= v_end_s ? {VW{1'b0}} : v_count_r + VW'(1'b1);
         end else begin
            h_count_r <= h_count_r + HW'(1'b1);
         end
      end
   end

   // One tick per line end when the period expires or the resync line ends.
   assign tick_s = line_end_s && (t_period_r != {TW{1'b0}}) &&
                   ((t_count_r == {TW{1'b0}}) || (v_count_r == t_sync_r));

   // Line timer; a config applied at the wrap restarts it on the new period.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         t_count_r <= RST_T_CNT;
         timer_r   <= 1'b0;
      end else if (i_pix_stb) begin
         timer_r <= tick_s;
         if (apply_s) begin
            t_count_r <= sh_t_period_r - TW'(1'b1);
         end else if (tick_s) begin
            t_count_r <= t_period_r - TW'(1'b1);
         end else if (line_end_s) begin
            t_count_r <= t_count_r - TW'(1'b1);
         end
      end
   end

   // Sync, blanking and coordinate decodes from the counters and active fields.
   always_comb begin
      hs_on_s       = (h_count_r >= h_fp_r) && (h_count_r < hs_end_s);
      vs_on_s       = (v_count_r >= vs_sta_s) && (v_count_r < vs_end_s);
      hblank_s      = (h_count_r < ha_sta_s);
      vblank_s      = (v_count_r >= v_act_r);
      o_hs          = hs_on_s ^ SYNC_NEG;
      o_vs          = vs_on_s ^ SYNC_NEG;
      o_hblank      = hblank_s;
      o_vblank      = vblank_s;
      o_active      = ~hblank_s & ~vblank_s;
      o_x           = hblank_s ? {HW{1'b0}} : h_count_r - ha_sta_s;
      o_y           = vblank_s ? v_act_r - VW'(1'b1) : v_count_r;
      o_line_start  = (h_count_r == {HW{1'b0}});
      o_frame_start = (h_count_r == {HW{1'b0}}) && (v_count_r == {VW{1'b0}});
      o_animate     = (v_count_r == v_act_r - VW'(1'b1)) && h_end_s;
   end

   assign o_cfg_busy = (state_r == ST_PEND);
   assign o_cfg_err  = err_r;
   assign o_timer    = timer_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a small raster:
// H fp/sync/bp/act 4/3/5/16 (LINE 28, HA_STA 12), V act/fp/sync/bp 10/3/2/3
// (FRAME 18, vs on v 13..14), timer period 4, resync line 13.
module tb_video_timing_gen;
   localparam int HW = 11;
   localparam int VW = 10;
   localparam int TW = 6;

   logic          clk = 1'b0;
   logic          rst, stb, cfg_valid;
   logic [HW-1:0] h_fp, h_sync, h_bp, h_act;
   logic [VW-1:0] v_act, v_fp, v_sync, v_bp, t_sync;
   logic [TW-1:0] t_period;
   logic          o_cfg_busy, o_cfg_err, o_hs, o_vs, o_hblank, o_vblank, o_active;
   logic [HW-1:0] o_x;
   logic [VW-1:0] o_y;
   logic          o_line_start, o_frame_start, o_animate, o_timer;
   int            checks = 0;
   int            fails  = 0;

   video_timing_gen #(
      .HW(HW), .VW(VW), .TW(TW), .SYNC_NEG(1'b1),
      .DEF_H_FP(4), .DEF_H_SYNC(3), .DEF_H_BP(5), .DEF_H_ACT(16),
      .DEF_V_ACT(10), .DEF_V_FP(3), .DEF_V_SYNC(2), .DEF_V_BP(3),
      .DEF_T_PERIOD(4), .DEF_T_SYNC(13)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_cfg_valid(cfg_valid),
      .i_h_fp(h_fp), .i_h_sync(h_sync), .i_h_bp(h_bp), .i_h_act(h_act),
      .i_v_act(v_act), .i_v_fp(v_fp), .i_v_sync(v_sync), .i_v_bp(v_bp),
      .i_t_period(t_period), .i_t_sync(t_sync),
      .o_cfg_busy(o_cfg_busy), .o_cfg_err(o_cfg_err), .o_hs(o_hs), .o_vs(o_vs),
      .o_hblank(o_hblank), .o_vblank(o_vblank), .o_active(o_active),
      .o_x(o_x), .o_y(o_y), .o_line_start(o_line_start),
      .o_frame_start(o_frame_start), .o_animate(o_animate), .o_timer(o_timer)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic cfg_set(input int hfp, input int hs, input int hbp, input int ha,
                          input int va, input int vfp, input int vs, input int vbp,
                          input int tp, input int ts);
      h_fp = HW'(hfp);  h_sync = HW'(hs); h_bp = HW'(hbp); h_act = HW'(ha);
      v_act = VW'(va);  v_fp = VW'(vfp);  v_sync = VW'(vs); v_bp = VW'(vbp);
      t_period = TW'(tp); t_sync = VW'(ts);
   endtask

   // Reset held across one edge; on return the raster sits at h=0, v=0.
   task automatic do_reset();
      rst = 1'b1; stb = 1'b1; cfg_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stb = 1'b1; cfg_valid = 1'b0;
      cfg_set(4, 3, 5, 16, 10, 3, 2, 3, 4, 13);
      run(2);
      checks++;
      if ({o_hs, o_vs, o_hblank, o_vblank, o_active, o_line_start, o_frame_start,
           o_animate, o_timer, o_cfg_busy, o_cfg_err} !== 11'b11100110000)
         $display("FAIL reset_flags: got %b expected %b", {o_hs, o_vs, o_hblank, o_vblank,
                  o_active, o_line_start, o_frame_start, o_animate, o_timer, o_cfg_busy,
                  o_cfg_err}, 11'b11100110000);
      checks++;
      if (o_x !== 11'd0 || o_y !== 10'd0)
         $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", o_x, o_y);
      if (o_x !== 11'd0 || o_y !== 10'd0) fails++;
      if ({o_hs, o_vs, o_hblank, o_vblank, o_active, o_line_start, o_frame_start,
           o_animate, o_timer, o_cfg_busy, o_cfg_err} !== 11'b11100110000) fails++;
   endtask

   // Two default frames, every decode and the timer checked on every strobe.
   task automatic test_defaults();
      int h, v, pv;
      logic [8:0] exp_v, got_v;
      logic [HW-1:0] x_e;
      logic [VW-1:0] y_e;
      do_reset();
      for (int n = 0; n < 2 * 28 * 18; n++) begin
         h = n % 28; v = (n / 28) % 18; pv = (v + 17) % 18;
         exp_v[8] = !(h >= 4 && h < 7);
         exp_v[7] = !(v >= 13 && v < 15);
         exp_v[6] = (h < 12);
         exp_v[5] = (v >= 10);
         exp_v[4] = (h >= 12) && (v < 10);
         exp_v[3] = (h == 0);
         exp_v[2] = (h == 0) && (v == 0);
         exp_v[1] = (v == 9) && (h == 27);
         exp_v[0] = (h == 0) && (n > 0) && (pv == 3 || pv == 7 || pv == 11 || pv == 13 || pv == 17);
         x_e = (h < 12) ? HW'(0) : HW'(h - 12);
         y_e = (v >= 10) ? VW'(9) : VW'(v);
         got_v = {o_hs, o_vs, o_hblank, o_vblank, o_active, o_line_start, o_frame_start, o_animate, o_timer};
         checks++;
         if (got_v !== exp_v) begin
            fails++;
            $display("FAIL defaults_flags h=%0d v=%0d: got %b expected %b", h, v, got_v, exp_v);
         end
         checks++;
         if (o_x !== x_e) begin
            fails++;
            $display("FAIL defaults_x h=%0d v=%0d: got %0d expected %0d", h, v, o_x, x_e);
         end
         checks++;
         if (o_y !== y_e) begin
            fails++;
            $display("FAIL defaults_y h=%0d v=%0d: got %0d expected %0d", h, v, o_y, y_e);
         end
         step();
      end
   endtask

   // Strobe gaps hold the raster and timer, while rejects still pulse o_cfg_err.
   task automatic test_gap_reject();
      do_reset();
      run(4 * 28);
      checks++;
      if (o_timer !== 1'b1) begin fails++; $display("FAIL gap_timer_set: got %b expected 1", o_timer); end
      stb = 1'b0;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       cfg_set(4, 0, 5, 16, 10, 3, 2, 3, 4, 13);
            1:       cfg_set(4, 3, 5, 16, 10, 3, 2, 1023, 4, 13);
            default: cfg_set(4, 3, 5, 16, 10, 3, 2, 3, 4, 18);
         endcase
         cfg_valid = 1'b1;
         step();
         cfg_valid = 1'b0;
         checks++;
         if ({o_cfg_err, o_cfg_busy} !== 2'b10) begin
            fails++; $display("FAIL reject_%0d_pulse: got err,busy=%b expected 10", k, {o_cfg_err, o_cfg_busy});
         end
         step();
         checks++;
         if ({o_cfg_err, o_cfg_busy} !== 2'b00) begin
            fails++; $display("FAIL reject_%0d_clear: got err,busy=%b expected 00", k, {o_cfg_err, o_cfg_busy});
         end
      end
      checks++;
      if ({o_timer, o_line_start, o_y} !== {1'b1, 1'b1, 10'd4}) begin
         fails++; $display("FAIL gap_hold: got timer,ls,y=%b,%b,%0d expected 1,1,4", o_timer, o_line_start, o_y);
      end
      stb = 1'b1;
      step();
      checks++;
      if ({o_timer, o_line_start} !== 2'b00) begin
         fails++; $display("FAIL gap_resume: got timer,ls=%b expected 00", {o_timer, o_line_start});
      end
   endtask

   // Mid-frame load of a 15-line frame with the timer disabled.
   task automatic test_mode_switch();
      int h, v;
      logic [3:0] exp_v, got_v;
      logic [VW-1:0] y_e;
      do_reset();
      run(5 * 28);
      cfg_set(4, 3, 5, 16, 8, 2, 3, 2, 0, 13);
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      checks++;
      if (o_cfg_busy !== 1'b1) begin fails++; $display("FAIL switch_busy_rise: got %b expected 1", o_cfg_busy); end
      run(17 * 28 + 27 - (5 * 28 + 1));
      checks++;
      if ({o_cfg_busy, o_frame_start} !== 2'b10) begin
         fails++; $display("FAIL switch_busy_at_wrap: got busy,fs=%b expected 10", {o_cfg_busy, o_frame_start});
      end
      step();
      checks++;
      if ({o_cfg_busy, o_frame_start} !== 2'b01) begin
         fails++; $display("FAIL switch_busy_fall: got busy,fs=%b expected 01", {o_cfg_busy, o_frame_start});
      end
      for (int m = 0; m < 15 * 28; m++) begin
         h = m % 28; v = m / 28;
         exp_v = {!(v >= 10 && v < 13), (v >= 8), (h == 0 && v == 0), 1'b0};
         got_v = {o_vs, o_vblank, o_frame_start, (m > 0) ? o_timer : 1'b0};
         y_e = (v >= 8) ? VW'(7) : VW'(v);
         checks++;
         if (got_v !== exp_v || o_y !== y_e) begin
            fails++;
            $display("FAIL switch_frame h=%0d v=%0d: got vs,vb,fs,tm=%b y=%0d expected %b y=%0d",
                     h, v, got_v, o_y, exp_v, y_e);
         end
         step();
      end
      checks++;
      if (o_frame_start !== 1'b1) begin fails++; $display("FAIL switch_frame_len: got fs=%b expected 1", o_frame_start); end
   endtask

   // Two loads in one frame: the 12-line second one wins.
   task automatic test_overwrite();
      do_reset();
      run(2 * 28);
      cfg_set(4, 3, 5, 16, 8, 2, 3, 2, 4, 5);
      cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
      run(4 * 28 - (2 * 28 + 1));
      cfg_set(4, 3, 5, 16, 6, 2, 2, 2, 4, 5);
      cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
      checks++;
      if (o_cfg_busy !== 1'b1) begin fails++; $display("FAIL overwrite_busy: got %b expected 1", o_cfg_busy); end
      run(18 * 28 - (4 * 28 + 1));
      for (int l = 0; l < 12; l++) begin
         checks++;
         if ({o_vblank, o_vs, o_cfg_busy} !== {l >= 6, !(l == 8 || l == 9), 1'b0}) begin
            fails++; $display("FAIL overwrite_line %0d: got vb,vs,busy=%b expected %b",
                              l, {o_vblank, o_vs, o_cfg_busy}, {l >= 6, !(l == 8 || l == 9), 1'b0});
         end
         run(28);
      end
      checks++;
      if (o_frame_start !== 1'b1) begin fails++; $display("FAIL overwrite_frame_len: got fs=%b expected 1", o_frame_start); end
   endtask

   // A load in the wrap cycle waits a full frame before taking effect.
   task automatic test_back_to_back();
      run(11 * 28 + 27);
      cfg_set(4, 3, 5, 16, 8, 2, 3, 2, 4, 5);
      cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
      checks++;
      if ({o_frame_start, o_cfg_busy} !== 2'b11) begin
         fails++; $display("FAIL collide_capture: got fs,busy=%b expected 11", {o_frame_start, o_cfg_busy});
      end
      for (int l = 0; l < 12; l++) begin
         checks++;
         if ({o_vblank, o_cfg_busy} !== {l >= 6, 1'b1}) begin
            fails++; $display("FAIL collide_old_line %0d: got vb,busy=%b expected %b", l, {o_vblank, o_cfg_busy}, {l >= 6, 1'b1});
         end
         run(28);
      end
      for (int l = 0; l < 15; l++) begin
         checks++;
         if ({o_vblank, o_vs, o_cfg_busy} !== {l >= 8, !(l >= 10 && l < 13), 1'b0}) begin
            fails++; $display("FAIL collide_new_line %0d: got vb,vs,busy=%b expected %b",
                              l, {o_vblank, o_vs, o_cfg_busy}, {l >= 8, !(l >= 10 && l < 13), 1'b0});
         end
         run(28);
      end
      checks++;
      if (o_frame_start !== 1'b1) begin fails++; $display("FAIL collide_frame_len: got fs=%b expected 1", o_frame_start); end
   endtask

   // Reset between edges clears outputs at once and drops the pending 12-line config.
   task automatic test_async_reset();
      cfg_set(4, 3, 5, 16, 6, 2, 2, 2, 4, 5);
      cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
      run(40);
      checks++;
      if ({o_cfg_busy, o_line_start} !== 2'b10) begin
         fails++; $display("FAIL async_pre: got busy,ls=%b expected 10", {o_cfg_busy, o_line_start});
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({o_hs, o_vs, o_hblank, o_vblank, o_active, o_line_start, o_frame_start,
           o_animate, o_timer, o_cfg_busy, o_cfg_err, o_x, o_y} !== {11'b11100110000, 11'd0, 10'd0}) begin
         fails++; $display("FAIL async_immediate: got %b x=%0d y=%0d expected 11100110000 x=0 y=0",
                           {o_hs, o_vs, o_hblank, o_vblank, o_active, o_line_start, o_frame_start,
                            o_animate, o_timer, o_cfg_busy, o_cfg_err}, o_x, o_y);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int l = 0; l < 36; l++) begin
         checks++;
         if ({o_vblank, o_cfg_busy, o_frame_start} !== {(l % 18) >= 10, 1'b0, (l % 18) == 0}) begin
            fails++; $display("FAIL async_line %0d: got vb,busy,fs=%b expected %b",
                              l, {o_vblank, o_cfg_busy, o_frame_start}, {(l % 18) >= 10, 1'b0, (l % 18) == 0});
         end
         run(28);
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_gap_reject();
      test_mode_switch();
      test_overwrite();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
